// File: rtl/tvip_axi_if_if.sv
// tvip_axi_if_if: AXI4 signal bundle with master and slave views.
interface tvip_axi_if_if #(
    parameter int ID_WIDTH   = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic                    awvalid;
    logic                    awready;
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic                    rvalid;
    logic                    rready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst, awcache, awprot, awqos,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst, arcache, arprot, arqos,
        output arready,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready
    );

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst, awcache, awprot, awqos,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, arid, araddr, arlen, arsize, arburst, arcache, arprot, arqos,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready
    );
endinterface

// File: rtl/tvip_axi_if.sv
// tvip_axi_if: AXI4 slave responder backed by a word memory, one write and one read burst in flight.
module tvip_axi_if #(
    parameter int ID_WIDTH   = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_WORDS  = 1024
) (
    input logic          i_clk,
    input logic          i_rst,
    tvip_axi_if_if.slave axi
);
    localparam int NB     = DATA_WIDTH / 8;
    localparam int NB_LOG = $clog2(NB);
    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_WORDS * NB);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [2:0]            sz;
        logic [ADDR_WIDTH-1:0] bytes, aligned, total, base;
        logic                  wrap;
        sz      = (size > 3'(NB_LOG)) ? 3'(NB_LOG) : size;
        bytes   = ADDR_WIDTH'(1) << sz;
        aligned = a & ~(bytes - ADDR_WIDTH'(1));
        total   = bytes * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1));
        base    = a & ~(total - ADDR_WIDTH'(1));
        wrap    = (burst == 2'd2) && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        return (burst == 2'd0) ? a :
               wrap ? (base | ((aligned + bytes) & (total - ADDR_WIDTH'(1)))) :
               aligned + bytes;
    endfunction

    function automatic logic oob(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} >= MEM_BYTES;
    endfunction

    function automatic logic [IDX_W-1:0] widx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'(a >> NB_LOG);
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    logic unused_ok;
    assign unused_ok = ^{axi.awcache, axi.awprot, axi.awqos, axi.arcache, axi.arprot, axi.arqos};

    w_state_e              w_state_q, w_state_d;
    logic                  awready_q, wready_q, bvalid_q;
    logic [ID_WIDTH-1:0]   bid_q, aw_id_q;
    logic [1:0]            bresp_q, aw_burst_q;
    logic [ADDR_WIDTH-1:0] w_addr_q;
    logic [7:0]            aw_len_q, w_cnt_q;
    logic [2:0]            aw_size_q;
    logic                  w_err_q;
    logic                  aw_hs, w_hs, b_hs, w_last, w_oob, w_beat_err;
    logic [IDX_W-1:0]      w_idx;

    always_comb begin
        aw_hs      = axi.awvalid & awready_q;
        w_hs       = axi.wvalid & wready_q;
        b_hs       = bvalid_q & axi.bready;
        w_last     = w_cnt_q == aw_len_q;
        w_oob      = oob(w_addr_q);
        w_idx      = widx(w_addr_q);
        w_beat_err = w_oob | (axi.wlast != w_last);
        w_state_d  = aw_hs ? W_DATA : (w_hs && w_last) ? W_RESP : b_hs ? W_IDLE : w_state_q;
    end

    // Handshake outputs are registered from the next state so reset drives them all to 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            w_state_q  <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= 2'b00;
            aw_id_q    <= '0;
            w_addr_q   <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            w_cnt_q    <= '0;
            w_err_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= w_state_d == W_IDLE;
            wready_q  <= w_state_d == W_DATA;
            bvalid_q  <= w_state_d == W_RESP;
            if (aw_hs) begin
                aw_id_q    <= axi.awid;
                w_addr_q   <= axi.awaddr;
                aw_len_q   <= axi.awlen;
                aw_size_q  <= axi.awsize;
                aw_burst_q <= axi.awburst;
                w_cnt_q    <= '0;
                w_err_q    <= 1'b0;
            end
            if (w_hs) begin
                w_cnt_q  <= w_cnt_q + 8'd1;
                w_addr_q <= next_addr(w_addr_q, aw_len_q, aw_size_q, aw_burst_q);
                w_err_q  <= w_err_q | w_beat_err;
                if (w_last) begin
                    bid_q   <= aw_id_q;
                    bresp_q <= (w_err_q | w_beat_err) ? 2'b10 : 2'b00;
                end
            end
        end
    end

    always_ff @(posedge i_clk)
        if (!i_rst && w_hs && !w_oob)
            for (int b = 0; b < NB; b++)
                if (axi.wstrb[b]) mem_q[w_idx][b*8 +: 8] <= axi.wdata[b*8 +: 8];

    r_state_e              r_state_q, r_state_d;
    logic                  arready_q, rvalid_q, rlast_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q, ar_burst_q;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_load_addr;
    logic [7:0]            ar_len_q, r_cnt_q, r_load_cnt, r_load_len;
    logic [2:0]            ar_size_q;
    logic                  ar_hs, r_hs, r_last, r_load, r_load_oob;
    logic [IDX_W-1:0]      r_idx;

    // Each accepted beat loads its successor on the same edge, so rready held high streams one beat per cycle.
    always_comb begin
        ar_hs       = axi.arvalid & arready_q;
        r_hs        = rvalid_q & axi.rready;
        r_last      = r_cnt_q == ar_len_q;
        r_load      = ar_hs | (r_hs & ~r_last);
        r_load_addr = ar_hs ? axi.araddr : next_addr(r_addr_q, ar_len_q, ar_size_q, ar_burst_q);
        r_load_cnt  = ar_hs ? 8'd0 : r_cnt_q + 8'd1;
        r_load_len  = ar_hs ? axi.arlen : ar_len_q;
        r_load_oob  = oob(r_load_addr);
        r_idx       = widx(r_load_addr);
        r_state_d   = ar_hs ? R_DATA : (r_hs && r_last) ? R_IDLE : r_state_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q  <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rid_q      <= '0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
            r_addr_q   <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            r_cnt_q    <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= r_state_d == R_IDLE;
            rvalid_q  <= r_state_d == R_DATA;
            if (ar_hs) begin
                rid_q      <= axi.arid;
                ar_len_q   <= axi.arlen;
                ar_size_q  <= axi.arsize;
                ar_burst_q <= axi.arburst;
            end
            if (r_load) begin
                r_addr_q <= r_load_addr;
                r_cnt_q  <= r_load_cnt;
                rdata_q  <= r_load_oob ? '0 : mem_q[r_idx];
                rresp_q  <= r_load_oob ? 2'b10 : 2'b00;
                rlast_q  <= r_load_cnt == r_load_len;
            end
        end
    end

    assign axi.awready = awready_q;
    assign axi.wready  = wready_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bid     = bid_q;
    assign axi.bresp   = bresp_q;
    assign axi.arready = arready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rid     = rid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign axi.rlast   = rlast_q;
endmodule

// File: tb/tb_tvip_axi_if.sv
// tb_tvip_axi_if: scoreboard bench for the AXI4 slave responder.
module tb_tvip_axi_if;
    localparam int IDW = 8;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int MW  = 1024;
    localparam logic [31:0] MEM_BYTES = 32'(MW * DW / 8);

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [7:0]  id;
        int          idx;
    } r_exp_t;
    typedef struct {
        logic [7:0] id;
        logic [1:0] resp;
    } b_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tvip_axi_if_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();
    tvip_axi_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(MW)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .axi  (axi)
    );

    r_exp_t      rq[$];
    b_exp_t      bq[$];
    logic [63:0] model [MW];
    int          total = 0, bad = 0, cyc = 0, r_first = 0, r_end = 0;
    logic [89:0] outs;
    logic [10:0] held;

    assign outs = {axi.awready, axi.wready, axi.bvalid, axi.bid, axi.bresp, axi.arready,
                   axi.rvalid, axi.rid, axi.rdata, axi.rresp, axi.rlast};

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Size-3 beat addresses: wrap walks the aligned window modulo its length.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [1:0] burst, input int i);
        int unsigned tot;
        tot = 8 * (int'(len) + 1);
        if (burst == 2'd0 || i == 0) return a;
        if (burst == 2'd2 && (len == 1 || len == 3 || len == 7 || len == 15))
            return (a / tot) * tot + ((a % tot + 8 * i) % tot);
        return (a & ~32'h7) + 32'(8 * i);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && axi.rvalid && axi.rready) begin
            if (rq.size() == 0) chk("r_extra", 1, 0);
            else begin
                r_exp_t e;
                e = rq.pop_front();
                chk("rdata", axi.rdata, e.data);
                chk("rresp", axi.rresp, e.resp);
                chk("rlast", axi.rlast, e.last);
                chk("rid", axi.rid, e.id);
                if (e.idx == 0) r_first = cyc;
                if (e.last) r_end = cyc;
            end
        end
        if (!rst && axi.bvalid && axi.bready) begin
            if (bq.size() == 0) chk("b_extra", 1, 0);
            else begin
                b_exp_t e;
                e = bq.pop_front();
                chk("bresp", axi.bresp, e.resp);
                chk("bid", axi.bid, e.id);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_b();
        int n;
        n = 0;
        while (bq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("b_timeout", 32'(bq.size()), 0);
    endtask

    task automatic wait_r();
        int n;
        n = 0;
        while (rq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("r_timeout", 32'(rq.size()), 0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                      input logic [7:0] id, input logic [63:0] d0, input logic [7:0] strb,
                      input int bad_last, input logic [1:0] resp, input bit stall);
        int n;
        bq.push_back('{id: id, resp: resp});
        step();
        axi.awvalid = 1'b1;
        axi.awid    = id;
        axi.awaddr  = addr;
        axi.awlen   = len;
        axi.awsize  = 3'd3;
        axi.awburst = burst;
        n = 0;
        @(negedge clk);
        while (!axi.awready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("aw_timeout", 0, 1);
        step();
        axi.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            logic [31:0] a;
            axi.wvalid = 1'b1;
            axi.wdata  = d0 + 64'(i);
            axi.wstrb  = strb;
            axi.wlast  = (i == int'(len)) ^ (i == bad_last);
            n = 0;
            @(negedge clk);
            while (!axi.wready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) chk("w_timeout", 0, 1);
            a = beat_addr(addr, len, burst, i);
            if (a < MEM_BYTES)
                for (int b = 0; b < 8; b++)
                    if (strb[b]) model[a >> 3][b*8 +: 8] = axi.wdata[b*8 +: 8];
            step();
        end
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
        if (!stall) wait_b();
    endtask

    task automatic ar_issue(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [7:0] id, input int nexp);
        int n;
        for (int i = 0; i < nexp; i++) begin
            logic [31:0] a;
            a = beat_addr(addr, len, burst, i);
            rq.push_back('{data: (a < MEM_BYTES) ? model[a >> 3] : 64'h0,
                           resp: (a < MEM_BYTES) ? 2'b00 : 2'b10,
                           last: i == int'(len), id: id, idx: i});
        end
        step();
        axi.arvalid = 1'b1;
        axi.arid    = id;
        axi.araddr  = addr;
        axi.arlen   = len;
        axi.arsize  = 3'd3;
        axi.arburst = burst;
        n = 0;
        @(negedge clk);
        while (!axi.arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ar_timeout", 0, 1);
        step();
        axi.arvalid = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                      input logic [7:0] id);
        ar_issue(addr, len, burst, id, int'(len) + 1);
        wait_r();
    endtask

    initial begin
        int n;
        for (int i = 0; i < MW; i++) model[i] = 64'h0;
        {axi.awvalid, axi.awid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst} = '0;
        {axi.awcache, axi.awprot, axi.awqos, axi.arcache, axi.arprot, axi.arqos} = '0;
        {axi.wvalid, axi.wdata, axi.wstrb, axi.wlast} = '0;
        {axi.arvalid, axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst} = '0;
        axi.bready = 1'b1;
        axi.rready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_outs", outs, 0);
        @(negedge clk);
        chk("rst_ready", {axi.awready, axi.arready}, 2'b11);

        wr(32'h40, 8'd0, 2'd1, 8'h5A, 64'h1122334455667788, 8'hFF, -1, 2'b00, 1'b0);
        rd(32'h40, 8'd0, 2'd1, 8'h5B);

        wr(32'h100, 8'd3, 2'd1, 8'h21, 64'd1, 8'hFF, -1, 2'b00, 1'b0);
        rd(32'h100, 8'd3, 2'd1, 8'h22);
        chk("r_consec", 32'(r_end - r_first), 3);

        rd(32'h118, 8'd3, 2'd2, 8'h23);

        wr(32'h200, 8'd0, 2'd1, 8'h03, 64'h11111111_22222222, 8'hFF, -1, 2'b00, 1'b0);
        step();
        axi.bready = 1'b0;
        wr(32'h200, 8'd0, 2'd1, 8'h04, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, -1, 2'b00, 1'b1);
        n = 0;
        while (!axi.bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("b_stall_timeout", 0, 1);
        held = {axi.bvalid, axi.bid, axi.bresp};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("b_stall_hold", {axi.bvalid, axi.bid, axi.bresp}, held);
            chk("b_stall_valid", axi.bvalid, 1);
        end
        step();
        axi.bready = 1'b1;
        wait_b();
        rd(32'h200, 8'd0, 2'd1, 8'h05);

        wr(32'h0, 8'd0, 2'd1, 8'h06, 64'hDEADBEEF_CAFEF00D, 8'hFF, -1, 2'b00, 1'b0);
        wr(MEM_BYTES, 8'd0, 2'd1, 8'h07, 64'h01234567_89ABCDEF, 8'hFF, -1, 2'b10, 1'b0);
        rd(32'h0, 8'd0, 2'd1, 8'h08);
        rd(MEM_BYTES, 8'd0, 2'd1, 8'h09);
        wr(32'h300, 8'd3, 2'd1, 8'h0A, 64'h50, 8'hFF, 1, 2'b10, 1'b0);
        rd(32'h300, 8'd3, 2'd1, 8'h0B);

        ar_issue(32'h100, 8'd3, 2'd1, 8'h0C, 2);
        step();
        step();
        rst = 1'b1;
        axi.rready = 1'b0;
        step();
        rst = 1'b0;
        axi.rready = 1'b1;
        @(negedge clk);
        chk("midrst_outs", outs, 0);
        @(negedge clk);
        chk("midrst_ready", {axi.awready, axi.arready}, 2'b11);
        chk("midrst_left", 32'(rq.size()), 0);
        rq.delete();

        wr(32'h48, 8'd0, 2'd1, 8'h0D, 64'h0F0E0D0C_0B0A0908, 8'hFF, -1, 2'b00, 1'b0);
        rd(32'h48, 8'd0, 2'd1, 8'h0E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
